lmsm_sequencer: RTL and testbench
=================================

# lmsm_sequencer

Register-list sequencer for the multi-register load/store instructions (LM/SM) of the multicycle RISC datapath. It latches the 8-bit register list from the instruction and walks it lowest-index-first. For each set bit it presents one 3-bit register address, which drives the register-file address mux select, and a one-hot write/read strobe. The control FSM consumes one address per accepted memory beat. A 4-bit transfer count is provided for the memory-address offset.

## Interface
Parameters:
- `NREG`, 8: register-list width. Only 8 is supported.
- `AW`, 3: register address width, log2(NREG).
- `CW`, 4: transfer-count width, able to hold 0..NREG.

Ports:
- `clk`  in  1  system clock; rising-edge active.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load `reg_list` and begin; sampled only in IDLE.
- `reg_list`  in  NREG  register mask from the instruction; bit i selects register Ri.
- `advance`  in  1  current address consumed (memory beat accepted); honoured only while `valid`=1.
- `valid`  out  1  `reg_addr`/`reg_onehot` hold a pending transfer.
- `reg_addr`  out  AW  index of the lowest set bit of the pending mask.
- `reg_onehot`  out  NREG  one-hot decode of `reg_addr`; all zero when `valid`=0.
- `xfer_count`  out  CW  transfers completed since `start`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the list is finished.

## Operation
- Internal registers:
  - `pending` (NREG bits).
  - `xfer_count` (CW bits).
  - state ∈ {IDLE, ACTIVE, FINISH}.
- IDLE:
  - On `start`=1: `pending` ← `reg_list` and `xfer_count` ← 0.
  - Next state is ACTIVE if `reg_list` ≠ 0, otherwise FINISH.
  - `advance` is ignored in IDLE.
- ACTIVE:
  - `valid`=1.
  - `reg_addr` = priority-encode(`pending`), lowest index wins.
  - `reg_onehot` = 1 << `reg_addr`.
  - On `advance`=1: clear bit `reg_addr` in `pending` and increment `xfer_count`.
  - If the cleared bit was the last set bit, go to FINISH. Otherwise stay in ACTIVE, and the next address appears the following cycle.
  - `start` is ignored in ACTIVE.
- FINISH:
  - `done`=1, `valid`=0, `busy`=1 for exactly one cycle, then IDLE.
  - `xfer_count` holds its final value until the next accepted `start`.
- Outputs `reg_addr`, `reg_onehot` and `valid` are combinational from the registered `pending` and state only. No input feeds them combinationally.
- Width rules:
  - `xfer_count` saturates at NREG; overflow is impossible by construction.
  - `reg_addr` = 0 whenever `valid`=0.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - state IDLE, `pending`=0, `xfer_count`=0.
  - `valid`=0, `reg_addr`=0, `reg_onehot`=0, `busy`=0, `done`=0.
- Start latency: `start` high at edge N puts the first address valid in the cycle after edge N. For an empty list, `done` is high in that cycle instead.
- One address per cycle maximum. With `advance` held high, a list of k bits yields k consecutive valid cycles and then `done` on cycle k+1 after start.
- `advance` low: `reg_addr` is held stable indefinitely (back-pressure).
- `done` never coincides with `valid`.
- The earliest next `start` is accepted in the cycle after `done`.
- Reset asserted mid-list: immediate return to IDLE, and no `done` pulse.

## Configuration
- Macro `LMSM_ABORT_EN`.
- Defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in ACTIVE or FINISH forces IDLE on the next edge, clears `pending`, and suppresses `done`. `xfer_count` keeps the transfers completed so far.
  - `abort` has priority over `advance` in the same cycle: no count increment.
  - `abort` in IDLE has no effect.
- Undefined: the `abort` port does not exist and the behaviour is as above.

## Test plan
- Reset, then `start` with `reg_list`=8'b1010_0110 and `advance` held high:
  - `reg_addr` sequence 1, 2, 5, 7 on consecutive cycles, with `reg_onehot` 02, 04, 20, 80.
  - `done` on the next cycle; final `xfer_count`=4.
- `reg_list`=8'h00: no `valid` cycle; `done` the cycle after `start`; `xfer_count`=0.
- `reg_list`=8'hFF with `advance` toggled 1, 0, 1, 0, …:
  - Each address is held through the low cycles; sequence 0..7.
  - `done` after the 8th accepted beat; `xfer_count`=8.
- `start` pulsed again while ACTIVE with a different mask: ignored, and the original sequence completes unchanged.
- `rst_n` dropped after 2 of 4 transfers: all outputs return to reset values within the same cycle, and no `done` pulse.
- With `LMSM_ABORT_EN`: mask 8'h0F, `abort` and `advance` asserted together on the 3rd address:
  - IDLE on the next cycle, no `done`.
  - `xfer_count`=2.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// LM/SM register-list sequencer: walks an 8-bit mask lowest-index-first.
// Optional abort input enabled by defining LMSM_ABORT_EN.
module lmsm_sequencer #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NREG-1:0] reg_list,
  input  logic            advance,
`ifdef LMSM_ABORT_EN
  input  logic            abort,
`endif
  output logic            valid,
  output logic [AW-1:0]   reg_addr,
  output logic [NREG-1:0] reg_onehot,
  output logic [CW-1:0]   xfer_count,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FINISH
  } state_t;

  state_t          state_q;
  logic [NREG-1:0] pending_q;
  logic [CW-1:0]   count_q;
  logic            busy_q;
  logic            done_q;

  logic [AW-1:0]   enc;
  logic            found;
  logic [NREG-1:0] oh;
  logic            last;
  logic            abort_w;

`ifdef LMSM_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Lowest set bit of the pending mask wins.
  always_comb begin
    enc   = '0;
    found = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (pending_q[i] && !found) begin
        enc   = AW'(i);
        found = 1'b1;
      end
    end
  end

  assign valid      = (state_q == ACTIVE);
  assign reg_addr   = valid ? enc : '0;
  assign oh         = NREG'(1) << enc;
  assign reg_onehot = valid ? oh : '0;
  assign last       = ((pending_q & ~oh) == '0);
  assign xfer_count = count_q;
  assign busy       = busy_q;
  assign done       = done_q & ~abort_w;

  // Control FSM: latch mask, retire one bit per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pending_q <= reg_list;
            count_q   <= '0;
            busy_q    <= 1'b1;
            if (|reg_list) begin
              state_q <= ACTIVE;
            end else begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (abort_w) begin
            state_q   <= IDLE;
            pending_q <= '0;
            busy_q    <= 1'b0;
          end else if (advance) begin
            pending_q <= pending_q & ~oh;
            if (count_q < CW'(NREG)) begin
              count_q <= count_q + 1'b1;
            end
            if (last) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state_q   <= IDLE;
          pending_q <= '0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= '0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: vector table, hand sequences, random vs model.
// Abort scenarios run when LMSM_ABORT_EN is defined.
module tb_lmsm_sequencer;

`ifdef LMSM_ABORT_EN
  localparam bit AB_EN = 1'b1;
`else
  localparam bit AB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] reg_list;
  logic       advance;
  logic       abort;
  logic       valid;
  logic [2:0] reg_addr;
  logic [7:0] reg_onehot;
  logic [3:0] xfer_count;
  logic       busy;
  logic       done;

  lmsm_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .reg_list   (reg_list),
    .advance    (advance),
`ifdef LMSM_ABORT_EN
    .abort      (abort),
`endif
    .valid      (valid),
    .reg_addr   (reg_addr),
    .reg_onehot (reg_onehot),
    .xfer_count (xfer_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  list;
    bit          tog;
    int          n;
    logic [31:0] seq;
    int          cnt;
    int          dcyc;
  } vec_t;

  vec_t tbl[6];

  // Reference model: queue of register indices still to transfer.
  int q[$];
  bit m_fin;
  int m_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  int obs[$];
  int done_at;

  task automatic model_reset();
    q.delete();
    m_fin = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (AB_EN && abort && (q.size() > 0 || m_fin)) begin
      q.delete();
      m_fin = 1'b0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (q.size() > 0) begin
      if (advance) begin
        void'(q.pop_front());
        if (m_cnt < 8) m_cnt++;
        if (q.size() == 0) m_fin = 1'b1;
      end
    end else if (start) begin
      q.delete();
      for (int i = 0; i < 8; i++)
        if (reg_list[i]) q.push_back(i);
      m_cnt = 0;
      if (q.size() == 0) m_fin = 1'b1;
    end
  endtask

  task automatic cmp(string nm, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check(string nm);
    bit         ev;
    bit         eb;
    bit         ed;
    logic [2:0] ea;
    logic [7:0] eoh;
    logic [16:0] got;
    logic [16:0] exp;
    ev  = q.size() > 0;
    ea  = ev ? 3'(q[0]) : 3'd0;
    eoh = ev ? (8'd1 << ea) : 8'd0;
    eb  = ev || m_fin;
    ed  = m_fin && !(AB_EN && abort);
    got = {valid, reg_addr, reg_onehot, xfer_count, busy, done};
    exp = {ev, ea, eoh, 4'(m_cnt), eb, ed};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got v=%b a=%0d oh=%h c=%0d b=%b d=%b exp v=%b a=%0d oh=%h c=%0d b=%b d=%b",
               nm, cyc, valid, reg_addr, reg_onehot, xfer_count, busy, done,
               ev, ea, eoh, m_cnt, eb, ed);
    end
  endtask

  task automatic cycle(string nm, bit s, logic [7:0] l, bit a, bit ab);
    @(negedge clk);
    start    = s;
    reg_list = l;
    advance  = a;
    abort    = ab;
    #1;
    check(nm);
    if (valid && advance && !(AB_EN && abort)) obs.push_back(int'(reg_addr));
    if (done && done_at < 0) done_at = cyc;
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  function automatic logic [31:0] packobs();
    logic [31:0] r;
    r = '0;
    foreach (obs[i])
      if (i < 8) r[i*4 +: 4] = 4'(obs[i]);
    return r;
  endfunction

  task automatic begin_run(logic [7:0] l, bit a);
    obs.delete();
    done_at = -1;
    cyc = 0;
    cycle("start", 1'b1, l, a, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'hA6, 1'b0, 4, 32'h0000_7521, 4, 5};
    tbl[1] = '{8'h00, 1'b0, 0, 32'h0000_0000, 0, 1};
    tbl[2] = '{8'hFF, 1'b1, 8, 32'h7654_3210, 8, 16};
    tbl[3] = '{8'h80, 1'b0, 1, 32'h0000_0007, 1, 2};
    tbl[4] = '{8'h01, 1'b1, 1, 32'h0000_0000, 1, 2};
    tbl[5] = '{8'h81, 1'b1, 2, 32'h0000_0070, 2, 4};

    rst_n    = 1'b0;
    start    = 1'b0;
    reg_list = 8'h00;
    advance  = 1'b0;
    abort    = 1'b0;
    cyc      = 0;
    done_at  = -1;
    model_reset();
    #1;
    check("reset");
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("idle", 1'b0, 8'h00, 1'b1, 1'b0);

    foreach (tbl[t]) begin
      begin_run(tbl[t].list, !tbl[t].tog);
      for (int c = 1; c < 40 && done_at < 0; c++)
        cycle("vec", 1'b0, 8'($urandom),
              tbl[t].tog ? c[0] : 1'b1, 1'b0);
      cmp($sformatf("vec%0d_len", t), obs.size(), tbl[t].n);
      cmp($sformatf("vec%0d_seq", t), int'(packobs()), int'(tbl[t].seq));
      cmp($sformatf("vec%0d_done", t), done_at, tbl[t].dcyc);
      cycle("post", 1'b0, 8'h00, 1'b0, 1'b0);
      cmp($sformatf("vec%0d_cnt", t), int'(xfer_count), tbl[t].cnt);
    end

    // start pulsed while ACTIVE must not disturb the walk
    begin_run(8'hA6, 1'b1);
    for (int c = 1; c < 20 && done_at < 0; c++)
      cycle("restart", c == 2, 8'h18, 1'b1, 1'b0);
    cmp("restart_seq", int'(packobs()), 32'h7521);
    cmp("restart_done", done_at, 5);

    // reset dropped after two of four transfers
    begin_run(8'h0F, 1'b1);
    cycle("rst_a", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("rst_b", 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid");
    cmp("rst_busy", int'(busy), 0);
    cycle("rst_hold", 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_at = -1;
    for (int c = 0; c < 4; c++)
      cycle("rst_after", 1'b0, 8'h00, 1'b1, 1'b0);
    cmp("rst_nodone", done_at, -1);

`ifdef LMSM_ABORT_EN
    begin_run(8'h0F, 1'b1);
    cycle("ab_1", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("ab_2", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("ab_3", 1'b0, 8'h00, 1'b1, 1'b1);
    cycle("ab_idle", 1'b0, 8'h00, 1'b1, 1'b0);
    cmp("ab_busy", int'(busy), 0);
    cmp("ab_cnt", int'(xfer_count), 2);
    cmp("ab_nodone", done_at, -1);
    begin_run(8'h00, 1'b1);
    cycle("ab_fin", 1'b0, 8'h00, 1'b0, 1'b1);
    cmp("ab_fin_nodone", done_at, -1);
`endif

    // random traffic against the model
    done_at = -1;
    for (int r = 0; r < 600; r++) begin
      logic [7:0] l;
      l = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      cycle("rand", $urandom_range(0, 3) == 0, l,
            1'($urandom), AB_EN && ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
